upa2: RTL and testbench

Pipelined second-order predictor-coefficient update stage (G.726 UPA2) for the single-resource multi-channel ADPCM codec. It computes the unlimited coefficient A2T for one channel per transaction. A2T feeds LIMC directly downstream, which clamps it to A2P. Work is time-multiplexed across 32 channels, with a channel tag passed alongside each result. Scan ports match the rest of the codec.

---
 rtl/mcac_pkg.sv | 20 ++
 rtl/upa2_fa.sv | 24 ++
 rtl/upa2.sv | 178 +++++++++++++++++
 tb/tb_upa2.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcac_pkg.sv
// Shared constants and types for the multi-channel ADPCM codec datapath.
// Intermediates are 17-bit signed so that |fa| + |ua| fits without wrap.
package mcac_pkg;

  localparam int CHAN_W = 5;
  localparam int COEF_W = 16;
  localparam int INT_W  = 17;

  typedef logic signed [INT_W-1:0] int17_t;

  localparam int17_t A1_LIM   = 17'sd8191;
  localparam int17_t FA_MAX   = 17'sd32764;
  localparam int17_t UGA2_MAG = 17'sd16384;

  // Sign-extend a coefficient into the intermediate width.
  function automatic int17_t sext_coef(input logic [COEF_W-1:0] v);
    return $signed({v[COEF_W-1], v});
  endfunction

endpackage

// File: rtl/upa2_fa.sv
// Combinational a1 -> fa clamp: fa = 4*a1, saturated to +/-FA_MAX outside +/-A1_LIM.
// Shared with the UPA1 stage.
module upa2_fa
  import mcac_pkg::*;
(
  input  logic [COEF_W-1:0] i_a1,
  output int17_t            o_fa
);

  int17_t w_a1;

  // Clamp before the shift so the product never exceeds the intermediate range.
  always_comb begin
    w_a1 = sext_coef(i_a1);
    if (w_a1 > A1_LIM) begin
      o_fa = FA_MAX;
    end else if (w_a1 < -A1_LIM) begin
      o_fa = -FA_MAX;
    end else begin
      o_fa = w_a1 <<< 2;
    end
  end

endmodule

// File: rtl/upa2.sv
// Three-stage pipelined G.726 UPA2 update (unlimited a2t) with a global stall
// driven by the output handshake; results carry their channel tag in order.
module upa2 #(
  parameter int CHAN_W = mcac_pkg::CHAN_W,
  parameter int COEF_W = mcac_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic              pk0,
  input  logic              pk1,
  input  logic              pk2,
  input  logic              sigpk,
  input  logic [COEF_W-1:0] a1,
  input  logic [COEF_W-1:0] a2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAN_W-1:0] out_chan,
  output logic [COEF_W-1:0] a2t
);

  logic                w_en;
  mcac_pkg::int17_t    w_fa;

  logic                r_s1_valid;
  logic [CHAN_W-1:0]   r_s1_chan;
  logic                r_s1_pks1;
  logic                r_s1_pks2;
  logic                r_s1_sigpk;
  mcac_pkg::int17_t    r_s1_fa;
  logic [COEF_W-1:0]   r_s1_a2;

  mcac_pkg::int17_t    w_ua;
  mcac_pkg::int17_t    w_sfa;
  mcac_pkg::int17_t    w_t;
  mcac_pkg::int17_t    w_uga2;
  mcac_pkg::int17_t    w_ula2;

  logic                r_s2_valid;
  logic [CHAN_W-1:0]   r_s2_chan;
  mcac_pkg::int17_t    r_s2_uga2;
  mcac_pkg::int17_t    r_s2_ula2;
  logic [COEF_W-1:0]   r_s2_a2;

  mcac_pkg::int17_t    w_sum;

  logic                r_s3_valid;
  logic [CHAN_W-1:0]   r_out_chan;
  logic [COEF_W-1:0]   r_a2t;
  logic [4:0]          r_scan;

  // Whole pipeline advances together; bubbles are held, never collapsed.
  assign w_en     = !r_s3_valid || out_ready;
  assign in_ready = w_en;

  upa2_fa u_fa (
    .i_a1 (a1),
    .o_fa (w_fa)
  );

  // Stage 1: capture inputs, sign products and clamped fa.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_chan  <= '0;
      r_s1_pks1  <= 1'b0;
      r_s1_pks2  <= 1'b0;
      r_s1_sigpk <= 1'b0;
      r_s1_fa    <= '0;
      r_s1_a2    <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_chan  <= in_chan;
      r_s1_pks1  <= pk0 ^ pk1;
      r_s1_pks2  <= pk0 ^ pk2;
      r_s1_sigpk <= sigpk;
      r_s1_fa    <= w_fa;
      r_s1_a2    <= a2;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Gain term t = ua -/+ fa, then the two leakage/update increments.
  always_comb begin
    if (r_s1_pks2) begin
      w_ua = -mcac_pkg::UGA2_MAG;
    end else begin
      w_ua = mcac_pkg::UGA2_MAG;
    end
    if (r_s1_pks1) begin
      w_sfa = -r_s1_fa;
    end else begin
      w_sfa = r_s1_fa;
    end
    w_t = w_ua - w_sfa;
    if (r_s1_sigpk) begin
      w_uga2 = 17'sd0;
    end else begin
      w_uga2 = w_t >>> 7;
    end
    w_ula2 = -(mcac_pkg::sext_coef(r_s1_a2) >>> 7);
  end

  // Stage 2: register increments alongside the old a2 and tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_chan  <= '0;
      r_s2_uga2  <= '0;
      r_s2_ula2  <= '0;
      r_s2_a2    <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_chan  <= r_s1_chan;
      r_s2_uga2  <= w_uga2;
      r_s2_ula2  <= w_ula2;
      r_s2_a2    <= r_s1_a2;
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

  // Wrapping sum; LIMC downstream does the limiting.
  always_comb begin
    w_sum = mcac_pkg::sext_coef(r_s2_a2) + r_s2_uga2 + r_s2_ula2;
  end

  // Stage 3: output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s3_valid <= 1'b0;
      r_out_chan <= '0;
      r_a2t      <= '0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      r_out_chan <= r_s2_chan;
      r_a2t      <= w_sum[COEF_W-1:0];
    end else begin
      r_s3_valid <= r_s3_valid;
    end
  end

  // Scan outputs stay at 0 outside test-mode shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan <= 5'b0;
    end else if (test_mode && scan_enable) begin
      r_scan <= {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
    end else begin
      r_scan <= 5'b0;
    end
  end

  assign out_valid = r_s3_valid;
  assign out_chan  = r_out_chan;
  assign a2t       = r_a2t;
  assign scan_out0 = r_scan[0];
  assign scan_out1 = r_scan[1];
  assign scan_out2 = r_scan[2];
  assign scan_out3 = r_scan[3];
  assign scan_out4 = r_scan[4];

endmodule

// File: tb/tb_upa2.sv
// Scoreboard bench for upa2: the driver pushes hand-computed a2t values on
// acceptance, a negedge monitor pops and compares on every output transfer.
module tb_upa2;

  typedef struct packed {
    logic [4:0]  chan;
    logic [15:0] a2t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_in0 = 1'b0, scan_in1 = 1'b0, scan_in2 = 1'b0, scan_in3 = 1'b0, scan_in4 = 1'b0;
  logic        scan_enable = 1'b0, test_mode = 1'b0;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_chan = 5'd0;
  logic        pk0 = 1'b0, pk1 = 1'b0, pk2 = 1'b0, sigpk = 1'b0;
  logic [15:0] a1 = 16'h0000, a2 = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_chan;
  logic [15:0] a2t;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_a2t = 16'h0000;
  logic [4:0]  prev_chan = 5'd0;
  bit          stream_done = 1'b0;

  // Directed vectors: pk0 pk1 pk2 sigpk a1 a2 -> expected a2t
  logic        v_pk0 [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        v_pk1 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        v_pk2 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        v_sig [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] v_a1  [8] = '{16'h0000, 16'h0000, 16'd8191, 16'd8191,
                             16'h8000, 16'h0000, 16'h0000, 16'hE001};
  logic [15:0] v_a2  [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                             16'h0000, 16'd12288, 16'hD000, 16'h0100};
  logic [15:0] v_exp [8] = '{16'h0080, 16'hFF80, 16'hFF80, 16'h017F,
                             16'h017F, 16'h2FA0, 16'hD060, 16'h007E};

  upa2 dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_chan     (in_chan),
    .pk0         (pk0),
    .pk1         (pk1),
    .pk2         (pk2),
    .sigpk       (sigpk),
    .a1          (a1),
    .a2          (a2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_chan    (out_chan),
    .a2t         (a2t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_vec(input int idx, input logic [4:0] tag);
    pk0     = v_pk0[idx];
    pk1     = v_pk1[idx];
    pk2     = v_pk2[idx];
    sigpk   = v_sig[idx];
    a1      = v_a1[idx];
    a2      = v_a2[idx];
    in_chan = tag;
  endtask

  // Present one vector until accepted; expected result is queued at acceptance.
  task automatic send(input int idx, input logic [4:0] tag);
    bit acc = 1'b0;
    drive_vec(idx, tag);
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back('{chan: tag, a2t: v_exp[idx]});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: tag %0d never accepted, expected acceptance", tag);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: handshake invariant, stall stability, scoreboard pop.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_a2t", 32'(a2t), 32'(prev_a2t));
        chk("hold_chan", 32'(out_chan), 32'(prev_chan));
      end
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: chan %0d a2t %0h, expected no output", out_chan, a2t);
        end else begin
          chk("out_chan", 32'(out_chan), 32'(q[0].chan));
          chk("a2t", 32'(a2t), 32'(q[0].a2t));
          void'(q.pop_front());
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_a2t   <= a2t;
      prev_chan  <= out_chan;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, held and after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a2t", 32'(a2t), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_scan", 32'({scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b10110;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("func_scan", 32'({scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}), 32'd0);

    // Individual directed vectors, ready always high
    for (int i = 0; i < 8; i++) begin
      send(i, 5'(i));
      wait_drain();
    end

    // Back-to-back stream with out_ready pattern 1,0,0 repeating
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 5'(i));
        stream_done = 1'b1;
      end
      begin
        for (int c = 0; c < 300; c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
          if (stream_done && q.size() == 0) break;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three transactions in flight
    send(0, 5'd20);
    send(1, 5'd21);
    send(2, 5'd22);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("flushed_valid", 32'(out_valid), 32'd0);

    // Latency after release: acceptance edge counts as the first of three
    drive_vec(7, 5'd9);
    in_valid = 1'b1;
    chk("lat_ready", 32'(in_ready), 32'd1);
    q.push_back('{chan: 5'd9, a2t: v_exp[7]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_edge1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_edge2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_edge3", 32'(out_valid), 32'd1);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
